// File: rtl/timer_pkg.sv
// timer_pkg
// Shared constants for the multi-channel timer: the per-channel register
// offsets inside a 4-word channel window and the bit positions used in the
// CTRL and STATUS registers.
package timer_pkg;

    // Register offsets inside one channel window (address bits [1:0])
    typedef enum logic [1:0] {
        CTRL_OFS   = 2'd0,
        PERIOD_OFS = 2'd1,
        COUNT_OFS  = 2'd2,
        STATUS_OFS = 2'd3
    } reg_ofs_t;

    // CTRL bit positions
    localparam int EN_BIT = 0;
    localparam int AR_BIT = 1;
    localparam int IE_BIT = 2;

    // STATUS bit positions
    localparam int PEND_BIT = 0;

endpackage

// File: rtl/timer_canal.sv
// timer_canal
// One timer channel: CTRL (EN/AR/IE), PERIOD, down-counter COUNT and the
// latched PEND flag, plus the expiry logic driven by the shared tick.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   tick                  prescaler tick shared by all channels
//   we_ctrl/we_period/we_status  decoded one-cycle write strobes
//   wdata                 write data
//   ctrl, period, count, pend    register contents for the read mux
//   irq                   level interrupt, PEND & IE from flops only
module timer_canal
    import timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             we_ctrl,
    input  logic             we_period,
    input  logic             we_status,
    input  logic [WIDTH-1:0] wdata,
    output logic [2:0]       ctrl,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] count,
    output logic             pend,
    output logic             irq
);

    logic [2:0]       ctrl_q;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] count_q;
    logic             pend_q;
    logic             en;
    logic             ar;
    logic             expire;

    assign en     = ctrl_q[EN_BIT];
    assign ar     = ctrl_q[AR_BIT];
    assign expire = tick & en & (count_q == '0);

    // CTRL: a bus write always wins; otherwise a one-shot expiry drops EN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
        end else if (we_ctrl) begin
            ctrl_q <= wdata[2:0];
        end else if (expire && !ar) begin
            ctrl_q[EN_BIT] <= 1'b0;
        end
    end

    // PERIOD only changes on a bus write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_q <= '0;
        end else if (we_period) begin
            period_q <= wdata;
        end
    end

    // COUNT priority: PERIOD write, then enable load, then tick behaviour.
    // A one-shot expiry simply leaves COUNT at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (we_period) begin
            count_q <= wdata;
        end else if (we_ctrl && wdata[EN_BIT] && !en) begin
            count_q <= period_q;
        end else if (tick && en) begin
            if (count_q != '0) begin
                count_q <= count_q - 1'b1;
            end else if (ar) begin
                count_q <= period_q;
            end
        end
    end

    // PEND: setting on expiry beats a simultaneous write-1-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= 1'b0;
        end else if (expire) begin
            pend_q <= 1'b1;
        end else if (we_status && wdata[PEND_BIT]) begin
            pend_q <= 1'b0;
        end
    end

    assign ctrl   = ctrl_q;
    assign period = period_q;
    assign count  = count_q;
    assign pend   = pend_q;
    assign irq    = pend_q & ctrl_q[IE_BIT];

endmodule

// File: rtl/timer_multicanal.sv
// timer_multicanal
// Multi-channel programmable timer on the memory-mapped I/O bus. Holds the
// shared prescaler, the address decode and the combinational read mux; the
// channels themselves live in timer_canal.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   we, re       write strobe / read enable
//   addr, wdata  register address and write data
//   rdata        combinational read data (0 when re=0 or unmapped)
//   irq          per-channel level interrupt requests
module timer_multicanal
    import timer_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 16,
    parameter int PRESC_W = 8,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic [NUM_CH-1:0] irq
);

    localparam logic [ADDR_W-1:0] PRESC_ADDR = ADDR_W'(4 * NUM_CH);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;
    logic               presc_we;
    logic [ADDR_W-3:0]  ch_field;
    reg_ofs_t           ofs;

    logic [2:0]         ctrl_q   [NUM_CH];
    logic [WIDTH-1:0]   period_q [NUM_CH];
    logic [WIDTH-1:0]   count_q  [NUM_CH];
    logic [NUM_CH-1:0]  pend_q;

    assign ch_field = addr[ADDR_W-1:2];
    assign ofs      = reg_ofs_t'(addr[1:0]);
    assign presc_we = we & (addr == PRESC_ADDR);
    assign tick     = (presc_cnt == presc_q);

    // Prescaler: counts 0..PRESC and wraps on the tick cycle; writing PRESC
    // restarts the count so the new divisor takes effect from a clean phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q   <= '0;
            presc_cnt <= '0;
        end else if (presc_we) begin
            presc_q   <= wdata[PRESC_W-1:0];
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // One channel per 4-word window; addresses past the last window never
    // match any channel field.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = we & (ch_field == (ADDR_W-2)'(i));

        timer_canal #(
            .WIDTH(WIDTH)
        ) u_canal (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick),
            .we_ctrl  (sel & (ofs == CTRL_OFS)),
            .we_period(sel & (ofs == PERIOD_OFS)),
            .we_status(sel & (ofs == STATUS_OFS)),
            .wdata    (wdata),
            .ctrl     (ctrl_q[i]),
            .period   (period_q[i]),
            .count    (count_q[i]),
            .pend     (pend_q[i]),
            .irq      (irq[i])
        );
    end

    // Read mux: zero unless enabled and the address hits a mapped register.
    always_comb begin
        rdata = '0;
        if (re) begin
            if (addr == PRESC_ADDR) begin
                rdata = WIDTH'(presc_q);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_field == (ADDR_W-2)'(i)) begin
                    case (ofs)
                        CTRL_OFS:   rdata = WIDTH'(ctrl_q[i]);
                        PERIOD_OFS: rdata = period_q[i];
                        COUNT_OFS:  rdata = count_q[i];
                        STATUS_OFS: rdata[PEND_BIT] = pend_q[i];
                        default:    rdata = '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_multicanal.sv
// tb_timer_multicanal
// Self-checking bench for timer_multicanal (NUM_CH=4, WIDTH=16, ADDR_W=5).
// A vector table covers register access after reset; hand-written sequences
// cover the timing and same-edge corner cases.
module tb_timer_multicanal;

    logic        clk;
    logic        reset;
    logic        we;
    logic        re;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [3:0]  irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic        rd_en;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[17];

    timer_multicanal #(
        .NUM_CH (4),
        .WIDTH  (16),
        .PRESC_W(8),
        .ADDR_W (5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .we   (we),
        .re   (re),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata),
        .irq  (irq)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic writeReg(input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic readReg(input logic [4:0] a, output logic [15:0] d);
        addr = a;
        re   = 1'b1;
        #1;
        d  = rdata;
        re = 1'b0;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits up to maxCyc edges for irq[ch]; n is the edge count, -1 on timeout
    task automatic waitIrq(input int ch, input int maxCyc, output int n);
        n = -1;
        for (int k = 1; k <= maxCyc; k++) begin
            @(posedge clk);
            #1;
            if (irq[ch]) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        if (v.wr) writeReg(v.addr, v.wdata);
        addr = v.addr;
        re   = v.rd_en;
        #1;
        checkOutput($sformatf("vec%0d_rdata", idx), 32'(rdata), 32'(v.exp));
        re = 1'b0;
        #1;
    endtask

    initial begin
        logic [15:0] d;
        int          n;
        bit          seen;

        // wr, re, addr, wdata, expected rdata
        vecs[0]  = '{1'b0, 1'b1, 5'd0,  16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 5'd1,  16'h0000, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 5'd2,  16'h0000, 16'h0000};
        vecs[3]  = '{1'b0, 1'b1, 5'd3,  16'h0000, 16'h0000};
        vecs[4]  = '{1'b0, 1'b1, 5'd16, 16'h0000, 16'h0000};
        vecs[5]  = '{1'b1, 1'b1, 5'd2,  16'h55AA, 16'h0000};
        vecs[6]  = '{1'b1, 1'b1, 5'd14, 16'h1111, 16'h0000};
        vecs[7]  = '{1'b1, 1'b1, 5'd12, 16'hFFF2, 16'h0002};
        vecs[8]  = '{1'b1, 1'b1, 5'd13, 16'h1234, 16'h1234};
        vecs[9]  = '{1'b0, 1'b1, 5'd14, 16'h0000, 16'h1234};
        vecs[10] = '{1'b1, 1'b0, 5'd13, 16'h00FF, 16'h0000};
        vecs[11] = '{1'b0, 1'b1, 5'd14, 16'h0000, 16'h00FF};
        vecs[12] = '{1'b1, 1'b1, 5'd20, 16'hFFFF, 16'h0000};
        vecs[13] = '{1'b0, 1'b1, 5'd31, 16'h0000, 16'h0000};
        vecs[14] = '{1'b1, 1'b1, 5'd16, 16'h0003, 16'h0003};
        vecs[15] = '{1'b1, 1'b1, 5'd16, 16'h0000, 16'h0000};
        vecs[16] = '{1'b1, 1'b1, 5'd15, 16'h0001, 16'h0000};

        we    = 1'b0;
        re    = 1'b0;
        addr  = '0;
        wdata = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset state and basic register access
        checkOutput("reset_irq", 32'(irq), 32'h0);
        checkOutput("reset_rdata_re0", 32'(rdata), 32'h0);
        for (int i = 0; i < 17; i++) applyStimulus(vecs[i], i);
        checkOutput("table_irq", 32'(irq), 32'h0);

        // Auto-reload on ch0, PRESC=0, PERIOD=3
        $display("[TB] auto-reload ch0");
        writeReg(5'd1, 16'd3);
        writeReg(5'd0, 16'h0007);
        waitIrq(0, 20, n);
        checkOutput("ar_first_rise", 32'(n), 32'd4);
        writeReg(5'd3, 16'h0001);
        checkOutput("ar_cleared", 32'(irq[0]), 32'h0);
        waitIrq(0, 20, n);
        checkOutput("ar_interval", 32'(n + 1), 32'd4);
        writeReg(5'd3, 16'h0001);
        waitIrq(0, 20, n);
        checkOutput("ar_interval2", 32'(n + 1), 32'd4);
        writeReg(5'd0, 16'h0000);

        // One-shot on ch1 with PRESC=4, enabled on a tick edge
        $display("[TB] one-shot ch1");
        writeReg(5'd16, 16'd4);
        writeReg(5'd5, 16'd2);
        idle(3);
        writeReg(5'd4, 16'h0005);
        waitIrq(1, 40, n);
        checkOutput("os_rise", 32'(n), 32'd15);
        readReg(5'd4, d);
        checkOutput("os_ctrl_en_cleared", 32'(d), 32'h4);
        readReg(5'd6, d);
        checkOutput("os_count_zero", 32'(d), 32'h0);
        writeReg(5'd7, 16'h0001);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (irq[1]) seen = 1'b1;
        end
        checkOutput("os_no_second_expiry", 32'(seen), 32'h0);
        writeReg(5'd16, 16'd0);

        // IE masking on ch2
        $display("[TB] IE masking ch2");
        writeReg(5'd9, 16'd1);
        writeReg(5'd8, 16'h0001);
        idle(5);
        checkOutput("mask_irq_low", 32'(irq[2]), 32'h0);
        readReg(5'd11, d);
        checkOutput("mask_pend_set", 32'(d), 32'h1);
        writeReg(5'd8, 16'h0004);
        checkOutput("unmask_irq_high", 32'(irq[2]), 32'h1);
        readReg(5'd8, d);
        checkOutput("unmask_ctrl", 32'(d), 32'h4);
        writeReg(5'd11, 16'h0001);
        checkOutput("clear_irq_low", 32'(irq[2]), 32'h0);

        // Same-edge collisions on ch0 (PERIOD=3, AR, IE=0)
        $display("[TB] same-edge collisions ch0");
        writeReg(5'd0, 16'h0000);
        writeReg(5'd3, 16'h0001);
        writeReg(5'd1, 16'd3);
        writeReg(5'd0, 16'h0003);
        idle(3);
        writeReg(5'd3, 16'h0001);
        readReg(5'd3, d);
        checkOutput("set_beats_clear", 32'(d), 32'h1);
        writeReg(5'd3, 16'h0001);
        readReg(5'd3, d);
        checkOutput("clear_no_expiry", 32'(d), 32'h0);
        idle(2);
        writeReg(5'd1, 16'h0050);
        readReg(5'd2, d);
        checkOutput("period_write_wins", 32'(d), 32'h50);
        readReg(5'd3, d);
        checkOutput("pend_on_period_write", 32'(d), 32'h1);
        writeReg(5'd0, 16'h0000);

        // Reset while every channel is mid-count
        $display("[TB] reset mid-count");
        for (int c = 0; c < 4; c++) begin
            writeReg(5'(4 * c), 16'h0000);
            writeReg(5'(4 * c + 1), 16'd100);
            writeReg(5'(4 * c), 16'h0007);
        end
        idle(5);
        readReg(5'd14, d);
        checkOutput("mid_count_ch3", 32'(d), 32'd95);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("reset_async_irq", 32'(irq), 32'h0);
        for (int c = 0; c < 4; c++) begin
            readReg(5'(4 * c + 2), d);
            checkOutput($sformatf("reset_count_ch%0d", c), 32'(d), 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 150; k++) begin
            @(posedge clk);
            #1;
            if (irq != 4'h0) seen = 1'b1;
        end
        checkOutput("post_reset_quiet", 32'(seen), 32'h0);
        readReg(5'd2, d);
        checkOutput("post_reset_count0", 32'(d), 32'h0);
        readReg(5'd0, d);
        checkOutput("post_reset_ctrl0", 32'(d), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
